// File: rtl/r4mdc_pkg.sv
// Shared types and constants for the 16-point radix-4 MDC twiddle sequencer.
// The build option R4MDC_SEQ_FRAME_CNT_EN is consumed by r4mdc_twiddle_sequencer.
package r4mdc_pkg;

  localparam int R4MDC_N        = 16;
  localparam int R4MDC_RADIX    = 4;
  localparam int R4MDC_TW_IDX_W = 2;
  localparam int R4MDC_CNT_W    = $clog2(R4MDC_N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } r4mdc_state_e;

  // One control beat travelling alongside the butterfly pipeline.
  typedef struct packed {
    logic                      valid;
    logic                      sop;
    logic                      eop;
    logic [R4MDC_TW_IDX_W-1:0] index;
  } r4mdc_ctrl_t;

  // Builds the control beat for an accepted sample at frame position cnt.
  // Only the last quarter of the frame feeds the butterfly; everything else
  // (and every non-accept cycle) is a bubble with all fields zero.
  function automatic r4mdc_ctrl_t r4mdc_make_ctrl(input logic                   accept,
                                                  input logic [R4MDC_CNT_W-1:0] cnt);
    r4mdc_ctrl_t c;
    c = '0;
    if (accept && (cnt[3:2] == 2'(R4MDC_RADIX - 1))) begin
      c.valid = 1'b1;
      c.index = cnt[1:0];
      c.sop   = (cnt[1:0] == 2'd0);
      c.eop   = (cnt[1:0] == 2'(R4MDC_RADIX - 1));
    end else begin
      c = '0;
    end
    return c;
  endfunction

endpackage

// File: rtl/r4mdc_ctrl_delay.sv
// Fixed-depth shift register carrying the butterfly control beat to the
// multiplier inputs. Depth 0 degenerates to a plain wire.
module r4mdc_ctrl_delay
  import r4mdc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  r4mdc_ctrl_t d,
  output r4mdc_ctrl_t q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst_s;
      assign unused_clk_rst_s = &{1'b0, clk, rst};
      assign q = d;
    end else begin : g_pipe
      r4mdc_ctrl_t stage_r [DEPTH];

      // Shift every cycle; reset flushes every in-flight beat.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= '0;
          end
        end else begin
          stage_r[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign q = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/r4mdc_twiddle_sequencer.sv
// Control sequencer for a 16-point radix-4 MDC FFT stage: frame position
// counter, IDLE/RUN/DRAIN FSM, commutator/butterfly strobes and the delayed
// twiddle index. Optional frame counter: define R4MDC_SEQ_FRAME_CNT_EN.
module r4mdc_twiddle_sequencer
  import r4mdc_pkg::*;
#(
  parameter int TW_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [1:0]                comm_sel,
  output logic                      comm_we,
  output logic                      bf_en,
  output logic [R4MDC_TW_IDX_W-1:0] tw_index,
  output logic                      tw_valid,
  output logic                      tw_sop,
  output logic                      tw_eop,
`ifdef R4MDC_SEQ_FRAME_CNT_EN
  output logic [15:0]               frame_cnt,
`endif
  output logic                      busy
);

  localparam logic [R4MDC_CNT_W-1:0] CNT_LAST   = R4MDC_CNT_W'(R4MDC_N - 1);
  localparam logic [3:0]             DRAIN_LAST = 4'(TW_LAT);

  r4mdc_state_e             state_r;
  r4mdc_state_e             state_nxt_s;
  logic [R4MDC_CNT_W-1:0]   cnt_r;
  logic [3:0]               drain_cnt_r;
  logic                     in_ready_s;
  logic                     busy_s;
  logic                     accept_s;
  logic [1:0]               comm_sel_r;
  logic                     comm_we_r;
  r4mdc_ctrl_t              ctrl_nxt_s;
  r4mdc_ctrl_t              ctrl_r;
  r4mdc_ctrl_t              tw_ctrl_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a started frame always completes; stop only at a frame boundary.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en) state_nxt_s = ST_RUN;
        else    state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!en && accept_s && (cnt_r == CNT_LAST)) begin
          state_nxt_s = ST_DRAIN;
        end else if (!en && !accept_s && (cnt_r == '0)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) state_nxt_s = ST_IDLE;
        else                           state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State decode: handshake and activity flags.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b0;
    case (state_r)
      ST_IDLE:  begin in_ready_s = 1'b0; busy_s = 1'b0; end
      ST_RUN:   begin in_ready_s = 1'b1; busy_s = 1'b1; end
      ST_DRAIN: begin in_ready_s = 1'b0; busy_s = 1'b1; end
      default:  begin in_ready_s = 1'b0; busy_s = 1'b0; end
    endcase
    accept_s = in_valid & in_ready_s;
  end

  // Frame position: advances only on accept, so stalls keep their place.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + R4MDC_CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Drain timer: counts DRAIN cycles until the control pipeline is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt_r <= 4'd0;
    end else if (state_r == ST_DRAIN) begin
      drain_cnt_r <= drain_cnt_r + 4'd1;
    end else begin
      drain_cnt_r <= 4'd0;
    end
  end

  assign ctrl_nxt_s = r4mdc_make_ctrl(accept_s, cnt_r);

  // Commutator strobes and butterfly control, one cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      comm_we_r  <= 1'b0;
      comm_sel_r <= 2'd0;
      ctrl_r     <= '0;
    end else begin
      comm_we_r  <= accept_s;
      comm_sel_r <= accept_s ? cnt_r[3:2] : 2'd0;
      ctrl_r     <= ctrl_nxt_s;
    end
  end

  r4mdc_ctrl_delay #(
    .DEPTH (TW_LAT)
  ) u_ctrl_delay (
    .clk (clk),
    .rst (rst),
    .d   (ctrl_r),
    .q   (tw_ctrl_s)
  );

`ifdef R4MDC_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;

  // Completed-frame count, stepped by each last butterfly output.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= 16'd0;
    end else if (tw_ctrl_s.eop) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

  assign in_ready = in_ready_s;
  assign busy     = busy_s;
  assign comm_we  = comm_we_r;
  assign comm_sel = comm_sel_r;
  assign bf_en    = ctrl_r.valid;
  assign tw_valid = tw_ctrl_s.valid;
  assign tw_index = tw_ctrl_s.index;
  assign tw_sop   = tw_ctrl_s.sop;
  assign tw_eop   = tw_ctrl_s.eop;

endmodule

// File: tb/tb_r4mdc_twiddle_sequencer.sv
// Self-checking bench: a TW_LAT=2 instance and a TW_LAT=0 instance share the
// stimulus; expectations come from a cycle-indexed schedule built from the
// frame-position rules.
module tb_r4mdc_twiddle_sequencer;

  localparam int LAT  = 2;
  localparam int NCYC = 4096;

  logic clk = 1'b0;
  logic rst, en, in_valid;

  logic       in_ready, comm_we, bf_en, tw_valid, tw_sop, tw_eop, busy;
  logic [1:0] comm_sel, tw_index;
  logic       in_ready0, comm_we0, bf_en0, tw_valid0, tw_sop0, tw_eop0, busy0;
  logic [1:0] comm_sel0, tw_index0;
`ifdef R4MDC_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt, frame_cnt0;
`endif

  always #5 clk = ~clk;

  r4mdc_twiddle_sequencer #(.TW_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .comm_sel(comm_sel), .comm_we(comm_we), .bf_en(bf_en), .tw_index(tw_index),
    .tw_valid(tw_valid), .tw_sop(tw_sop), .tw_eop(tw_eop),
`ifdef R4MDC_SEQ_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .busy(busy)
  );

  r4mdc_twiddle_sequencer #(.TW_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready0),
    .comm_sel(comm_sel0), .comm_we(comm_we0), .bf_en(bf_en0), .tw_index(tw_index0),
    .tw_valid(tw_valid0), .tw_sop(tw_sop0), .tw_eop(tw_eop0),
`ifdef R4MDC_SEQ_FRAME_CNT_EN
    .frame_cnt(frame_cnt0),
`endif
    .busy(busy0)
  );

  // Expected schedule, indexed by cycle number.
  bit       e_we [NCYC];
  bit [1:0] e_sel[NCYC];
  bit       e_bf [NCYC];
  bit [1:0] e_bi [NCYC];
  bit       e_tv [NCYC];
  bit [1:0] e_ti [NCYC];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit m_run  = 1'b0;
  int m_pos  = 0;
  int m_drain = 0;
  int m_drain0 = 0;
  int m_fc = 0;
  int m_fc0 = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_bound(input string tag, input bit ok);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=timeout expected=completion", tag, cyc);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", 16'(in_ready), 16'(m_run));
    chk("busy", 16'(busy), 16'(m_run || m_drain > 0));
    chk("comm_we", 16'(comm_we), 16'(e_we[cyc]));
    if (e_we[cyc]) chk("comm_sel", 16'(comm_sel), 16'(e_sel[cyc]));
    chk("bf_en", 16'(bf_en), 16'(e_bf[cyc]));
    chk("tw_valid", 16'(tw_valid), 16'(e_tv[cyc]));
    if (e_tv[cyc]) chk("tw_index", 16'(tw_index), 16'(e_ti[cyc]));
    chk("tw_sop", 16'(tw_sop), 16'(e_tv[cyc] && e_ti[cyc] == 2'd0));
    chk("tw_eop", 16'(tw_eop), 16'(e_tv[cyc] && e_ti[cyc] == 2'd3));
    chk("lat0_in_ready", 16'(in_ready0), 16'(m_run));
    chk("lat0_busy", 16'(busy0), 16'(m_run || m_drain0 > 0));
    chk("lat0_comm_we", 16'(comm_we0), 16'(e_we[cyc]));
    if (e_we[cyc]) chk("lat0_comm_sel", 16'(comm_sel0), 16'(e_sel[cyc]));
    chk("lat0_bf_en", 16'(bf_en0), 16'(e_bf[cyc]));
    chk("lat0_tw_valid", 16'(tw_valid0), 16'(e_bf[cyc]));
    if (e_bf[cyc]) chk("lat0_tw_index", 16'(tw_index0), 16'(e_bi[cyc]));
    chk("lat0_tw_sop", 16'(tw_sop0), 16'(e_bf[cyc] && e_bi[cyc] == 2'd0));
    chk("lat0_tw_eop", 16'(tw_eop0), 16'(e_bf[cyc] && e_bi[cyc] == 2'd3));
`ifdef R4MDC_SEQ_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, 16'(m_fc));
    chk("lat0_frame_cnt", frame_cnt0, 16'(m_fc0));
`endif
    if (e_tv[cyc] && e_ti[cyc] == 2'd3) m_fc++;
    if (e_bf[cyc] && e_bi[cyc] == 2'd3) m_fc0++;
  endtask

  // Apply one cycle of inputs, update the reference schedule, then check.
  task automatic step(input bit en_v, input bit iv_v, input bit rst_v);
    bit acc;
    rst = rst_v; en = en_v; in_valid = iv_v;
    acc = !rst_v && m_run && iv_v;
    if (rst_v) begin
      for (int k = cyc + 1; k < NCYC; k++) begin
        e_we[k] = 1'b0; e_bf[k] = 1'b0; e_tv[k] = 1'b0;
      end
      m_run = 1'b0; m_pos = 0; m_drain = 0; m_drain0 = 0; m_fc = 0; m_fc0 = 0;
    end else begin
      if (acc) begin
        e_we[cyc+1]  = 1'b1;
        e_sel[cyc+1] = 2'(m_pos / 4);
        if (m_pos >= 12) begin
          e_bf[cyc+1]     = 1'b1;
          e_bi[cyc+1]     = 2'(m_pos % 4);
          e_tv[cyc+1+LAT] = 1'b1;
          e_ti[cyc+1+LAT] = 2'(m_pos % 4);
        end
      end
      if (m_drain0 > 0) m_drain0--;
      if (m_drain > 0) begin
        m_drain--;
      end else if (!m_run) begin
        if (en_v) m_run = 1'b1;
      end else if (!en_v && ((acc && m_pos == 15) || (!acc && m_pos == 0))) begin
        m_run = 1'b0; m_drain = LAT + 1; m_drain0 = 1;
      end
      if (acc) m_pos = (m_pos + 1) % 16;
    end
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  // Feed n_acc samples; en stays high until en_until samples are accepted.
  task automatic frame_run(input int n_acc, input int en_until, input int stall_pos,
                           input int stall_len, input bit rnd);
    int done = 0;
    int guard = 0;
    int stall = 0;
    bit e, v;
    while (done < n_acc && guard < 400) begin
      e = (done < en_until);
      v = 1'b1;
      if (stall > 0) begin
        v = 1'b0;
        stall--;
      end else if (rnd) begin
        v = ($urandom_range(0, 3) != 0);
      end else begin
        v = 1'b1;
      end
      if (m_run && v) begin
        done++;
        if (m_pos == stall_pos) stall = stall_len;
      end
      step(e, v, 1'b0);
      guard++;
    end
    chk_bound("frame_run", guard < 400);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((m_run || m_drain > 0) && g < 64) begin
      step(1'b0, 1'b0, 1'b0);
      g++;
    end
    chk_bound("wait_idle", g < 64);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int nf, eu, g;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0;

    // Reset, including reset winning over en.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Single continuous frame, en released on the last accept.
    frame_run(16, 15, -1, 0, 1'b0);
    wait_idle();
    // Three-cycle stall after sample 13.
    frame_run(16, 15, 13, 3, 1'b0);
    wait_idle();
    // en dropped after sample 5: the frame still completes.
    frame_run(16, 6, -1, 0, 1'b0);
    wait_idle();
    // Two back-to-back frames.
    frame_run(32, 31, -1, 0, 1'b0);
    wait_idle();
    // en held through sample 15, then dropped at the clean boundary.
    frame_run(16, 16, -1, 0, 1'b1);
    wait_idle();

    // Randomised frames, gaps and en release points.
    for (int f = 0; f < 5; f++) begin
      nf = $urandom_range(1, 2);
      eu = $urandom_range(16 * (nf - 1) + 1, 16 * nf);
      frame_run(16 * nf, eu, $urandom_range(0, 15), $urandom_range(0, 3), 1'b1);
      wait_idle();
    end

    // Reset while the butterfly handles n=1: in-flight beats are dropped.
    step(1'b1, 1'b0, 1'b0);
    g = 0;
    while (!(e_bf[cyc] && e_bi[cyc] == 2'd1) && g < 100) begin
      step(1'b1, 1'b1, 1'b0);
      g++;
    end
    chk_bound("reach_bf_n1", g < 100);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    frame_run(16, 15, -1, 0, 1'b1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
